// File: rtl/addrmap_pkg.sv
// Shared definitions for the address window mapper.
// Covers flag bit positions, config field codes and the window record.
package addrmap_pkg;

   localparam int ADDR_W = 24;

   localparam int FLG_EN   = 0;
   localparam int FLG_SRAM = 1;
   localparam int FLG_WR   = 2;
   localparam int FLG_ROM  = 3;

   localparam logic [1:0] FLD_BASE  = 2'd0;
   localparam logic [1:0] FLD_MASK  = 2'd1;
   localparam logic [1:0] FLD_OFS   = 2'd2;
   localparam logic [1:0] FLD_FLAGS = 2'd3;

   typedef struct packed {
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] mask;
      logic [ADDR_W-1:0] offset;
      logic [3:0]        flags;
   } window_t;

endpackage

// File: rtl/addrmap_match.sv
// Single-window address comparator: hit when enabled and the masked bits equal the base.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module addrmap_match #(
   parameter int AW = 24
) (
   input  logic [AW-1:0] addr,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] mask,
   input  logic          en,
   output logic          hit
);

   assign hit = en & ((addr & mask) == (base & mask));

endmodule

// File: rtl/address_window_map.sv
// Programmable SNES-to-PSRAM address decoder with NWIN prioritised windows; ADDRMAP_HITCNT_EN adds per-window hit counters.
// Latency: 2 cycles from SNES_ADDR_VALID to out_valid, one result per cycle.
// Backpressure: none on the bus side; table commits wait for an idle pipeline (cfg_busy).
module address_window_map
   import addrmap_pkg::*;
#(
   parameter int NWIN = 8,
   parameter int IDXW = (NWIN > 1) ? $clog2(NWIN) : 1,
   parameter int AW   = ADDR_W
) (
   input  logic            CLK,
   input  logic            RST_N,
`ifdef ADDRMAP_HITCNT_EN
   input  logic [IDXW-1:0] cnt_sel,
   input  logic            cnt_clr,
   output logic [15:0]     cnt_val,
`endif
   input  logic [AW-1:0]   SNES_ADDR,
   input  logic            SNES_ADDR_VALID,
   input  logic            SNES_WR,
   input  logic            cfg_we,
   input  logic [IDXW-1:0] cfg_idx,
   input  logic [1:0]      cfg_field,
   input  logic [AW-1:0]   cfg_data,
   input  logic            cfg_commit,
   output logic            cfg_busy,
   output logic [AW-1:0]   ROM_ADDR,
   output logic            ROM_HIT,
   output logic            IS_SAVERAM,
   output logic            IS_WRITABLE,
   output logic            IS_ROM,
   output logic [IDXW-1:0] win_idx,
   output logic            out_valid,
   output logic            wp_violation
);

   window_t shadow     [NWIN];
   window_t shadow_nxt [NWIN];
   window_t active     [NWIN];

   logic [NWIN-1:0] match_vec;
   logic            copy_ok;

   logic            s1_vld;
   logic [NWIN-1:0] s1_hit;
   logic [AW-1:0]   s1_addr;
   logic            s1_wr;

   logic [IDXW-1:0] win_sel;
   logic            win_found;
   window_t         sel_win;
   logic [AW-1:0]   rom_addr_nxt;

   // Shadow image after this cycle's write; a same-edge commit copies this so the write is included.
   always_comb begin
      shadow_nxt = shadow;
      if (cfg_we && !cfg_busy && (int'(cfg_idx) < NWIN)) begin
         case (cfg_field)
            FLD_BASE:  shadow_nxt[cfg_idx].base[AW-1:0]   = cfg_data;
            FLD_MASK:  shadow_nxt[cfg_idx].mask[AW-1:0]   = cfg_data;
            FLD_OFS:   shadow_nxt[cfg_idx].offset[AW-1:0] = cfg_data;
            FLD_FLAGS: shadow_nxt[cfg_idx].flags          = cfg_data[3:0];
            default: ;
         endcase
      end
   end

   // Copying only with stage 1 empty and no new strobe keeps every in-flight decode on one table.
   assign copy_ok = !SNES_ADDR_VALID && !s1_vld;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         shadow   <= '{default: '0};
         active   <= '{default: '0};
         cfg_busy <= 1'b0;
      end else begin
         shadow <= shadow_nxt;
         if ((cfg_commit || cfg_busy) && copy_ok) begin
            active   <= shadow_nxt;
            cfg_busy <= 1'b0;
         end else if (cfg_commit) begin
            cfg_busy <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NWIN; i++) begin : g_win
      addrmap_match #(.AW(AW)) u_match (
         .addr (SNES_ADDR),
         .base (active[i].base[AW-1:0]),
         .mask (active[i].mask[AW-1:0]),
         .en   (active[i].flags[FLG_EN]),
         .hit  (match_vec[i])
      );
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         s1_vld  <= 1'b0;
         s1_hit  <= '0;
         s1_addr <= '0;
         s1_wr   <= 1'b0;
      end else begin
         s1_vld <= SNES_ADDR_VALID;
         if (SNES_ADDR_VALID) begin
            s1_hit  <= match_vec;
            s1_addr <= SNES_ADDR;
            s1_wr   <= SNES_WR;
         end
      end
   end

   always_comb begin
      win_sel   = '0;
      win_found = 1'b0;
      for (int i = NWIN - 1; i >= 0; i--) begin
         if (s1_hit[i]) begin
            win_sel   = IDXW'(i);
            win_found = 1'b1;
         end
      end
   end

   assign sel_win      = active[win_sel];
   assign rom_addr_nxt = (s1_addr & ~sel_win.mask[AW-1:0]) + sel_win.offset[AW-1:0];

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         out_valid    <= 1'b0;
         ROM_ADDR     <= '0;
         ROM_HIT      <= 1'b0;
         IS_SAVERAM   <= 1'b0;
         IS_WRITABLE  <= 1'b0;
         IS_ROM       <= 1'b0;
         win_idx      <= '0;
         wp_violation <= 1'b0;
      end else begin
         out_valid <= s1_vld;
         if (s1_vld) begin
            ROM_ADDR     <= win_found ? rom_addr_nxt : '0;
            ROM_HIT      <= win_found;
            IS_SAVERAM   <= win_found & sel_win.flags[FLG_SRAM];
            IS_WRITABLE  <= win_found & sel_win.flags[FLG_WR];
            IS_ROM       <= win_found & sel_win.flags[FLG_ROM];
            win_idx      <= win_found ? win_sel : '0;
            wp_violation <= win_found & s1_wr & ~sel_win.flags[FLG_WR];
         end
      end
   end

`ifdef ADDRMAP_HITCNT_EN
   logic [15:0] hit_cnt [NWIN];

   // Clear beats a same-cycle increment; counters stick at 0xFFFF.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hit_cnt <= '{default: '0};
         cnt_val <= '0;
      end else begin
         for (int i = 0; i < NWIN; i++) begin
            if (cnt_clr && (int'(cnt_sel) == i)) begin
               hit_cnt[i] <= '0;
            end else if (out_valid && ROM_HIT && (int'(win_idx) == i) && (hit_cnt[i] != 16'hFFFF)) begin
               hit_cnt[i] <= hit_cnt[i] + 16'd1;
            end
         end
         cnt_val <= (int'(cnt_sel) < NWIN) ? hit_cnt[cnt_sel] : 16'h0;
      end
   end
`endif

endmodule

// File: tb/tb_address_window_map.sv
// Randomised and directed checks of address_window_map against a table-level reference model.
`timescale 1ns/1ps
module tb_address_window_map;

   localparam int NWIN = 8;
   localparam int IDXW = 3;
   localparam int AW   = 24;

   logic            clk;
   logic            rst_n;
   logic            vld, wr, we, commit;
   logic [AW-1:0]   addr, data;
   logic [IDXW-1:0] idx;
   logic [1:0]      field;

   logic            cfg_busy, out_valid;
   logic [AW-1:0]   rom_addr;
   logic            rom_hit, is_sram, is_wrt, is_rom, wp;
   logic [IDXW-1:0] w_idx;
   logic [31:0]     dut_outs;

`ifdef ADDRMAP_HITCNT_EN
   logic [IDXW-1:0] cnt_sel;
   logic            cnt_clr;
   logic [15:0]     cnt_val;
   int              m_cnt [NWIN];
   logic [15:0]     exp_cnt;
`endif

   int checks = 0;
   int errors = 0;

   address_window_map #(.NWIN(NWIN), .AW(AW)) dut (
      .CLK             (clk),
      .RST_N           (rst_n),
`ifdef ADDRMAP_HITCNT_EN
      .cnt_sel         (cnt_sel),
      .cnt_clr         (cnt_clr),
      .cnt_val         (cnt_val),
`endif
      .SNES_ADDR       (addr),
      .SNES_ADDR_VALID (vld),
      .SNES_WR         (wr),
      .cfg_we          (we),
      .cfg_idx         (idx),
      .cfg_field       (field),
      .cfg_data        (data),
      .cfg_commit      (commit),
      .cfg_busy        (cfg_busy),
      .ROM_ADDR        (rom_addr),
      .ROM_HIT         (rom_hit),
      .IS_SAVERAM      (is_sram),
      .IS_WRITABLE     (is_wrt),
      .IS_ROM          (is_rom),
      .win_idx         (w_idx),
      .out_valid       (out_valid),
      .wp_violation    (wp)
   );

   assign dut_outs = {rom_addr, rom_hit, is_sram, is_wrt, is_rom, w_idx, wp};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [23:0] base;
      logic [23:0] mask;
      logic [23:0] ofs;
      logic [3:0]  flags;
   } mwin_t;

   typedef struct packed {
      logic [23:0] addr;
      logic        hit;
      logic        sram;
      logic        wrt;
      logic        rom;
      logic [2:0]  idx;
      logic        wp;
   } res_t;

   mwin_t m_sh  [NWIN];
   mwin_t m_act [NWIN];
   bit    m_busy;
   bit    m_prev_vld;
   int    cyc = 0;
   int    due_q [$];
   res_t  res_q [$];
   bit    exp_vld;
   res_t  exp_res;

   function automatic res_t decode(logic [23:0] a, logic w);
      res_t r = '0;
      for (int i = 0; i < NWIN; i++) begin
         if (m_act[i].flags[0] && (((a ^ m_act[i].base) & m_act[i].mask) == 24'h0)) begin
            r.addr = (a & ~m_act[i].mask) + m_act[i].ofs;
            r.hit  = 1'b1;
            r.sram = m_act[i].flags[1];
            r.wrt  = m_act[i].flags[2];
            r.rom  = m_act[i].flags[3];
            r.idx  = 3'(i);
            r.wp   = w & ~m_act[i].flags[2];
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         for (int i = 0; i < NWIN; i++) begin
            m_sh[i]  = '{24'h0, 24'h0, 24'h0, 4'h0};
            m_act[i] = '{24'h0, 24'h0, 24'h0, 4'h0};
         end
         m_busy = 0; m_prev_vld = 0; exp_vld = 0; exp_res = '0;
         due_q.delete(); res_q.delete();
`ifdef ADDRMAP_HITCNT_EN
         for (int i = 0; i < NWIN; i++) m_cnt[i] = 0;
         exp_cnt = 16'h0;
`endif
         cyc++;
         return;
      end
`ifdef ADDRMAP_HITCNT_EN
      exp_cnt = 16'(m_cnt[cnt_sel]);
      if (exp_vld && exp_res.hit && !(cnt_clr && cnt_sel == exp_res.idx) && m_cnt[exp_res.idx] < 65535)
         m_cnt[exp_res.idx]++;
      if (cnt_clr) m_cnt[cnt_sel] = 0;
`endif
      if (vld) begin
         due_q.push_back(cyc + 2);
         res_q.push_back(decode(addr, wr));
      end
      if (we && !m_busy) begin
         case (field)
            2'd0: m_sh[idx].base = data;
            2'd1: m_sh[idx].mask = data;
            2'd2: m_sh[idx].ofs = data;
            default: m_sh[idx].flags = data[3:0];
         endcase
      end
      if ((commit || m_busy) && !vld && !m_prev_vld) begin
         for (int i = 0; i < NWIN; i++) m_act[i] = m_sh[i];
         m_busy = 0;
      end else if (commit) begin
         m_busy = 1;
      end
      m_prev_vld = vld;
      cyc++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         exp_vld = 1;
         exp_res = res_q.pop_front();
         void'(due_q.pop_front());
      end else begin
         exp_vld = 0;
      end
   endtask

   // ---------------- checking and driving ----------------
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(exp_vld));
      check("cfg_busy", 32'(cfg_busy), 32'(m_busy));
      check("outputs", dut_outs, 32'(exp_res));
`ifdef ADDRMAP_HITCNT_EN
      check("cnt_val", 32'(cnt_val), 32'(exp_cnt));
`endif
   endtask

   task automatic idle(int n);
      vld = 0; wr = 0; we = 0; commit = 0;
      repeat (n) cycle();
   endtask

   task automatic cfg(int i, logic [1:0] f, logic [23:0] d);
      we = 1; idx = 3'(i); field = f; data = d;
      cycle();
      we = 0;
   endtask

   task automatic set_win(int i, logic [23:0] b, logic [23:0] m, logic [23:0] o, logic [3:0] f);
      cfg(i, 2'd0, b);
      cfg(i, 2'd1, m);
      cfg(i, 2'd2, o);
      cfg(i, 2'd3, {20'h0, f});
   endtask

   task automatic do_commit();
      commit = 1;
      cycle();
      commit = 0;
   endtask

   task automatic strobe(logic [23:0] a, logic w);
      vld = 1; addr = a; wr = w;
      cycle();
      vld = 0; wr = 0;
   endtask

   initial begin
      rst_n = 0; vld = 0; wr = 0; we = 0; commit = 0;
      addr = '0; data = '0; idx = '0; field = '0;
`ifdef ADDRMAP_HITCNT_EN
      cnt_sel = '0; cnt_clr = 0;
`endif
      idle(2);
      check("rst_outs", dut_outs, 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      rst_n = 1;
      idle(1);

      // LoROM-style window 0
      set_win(0, 24'h008000, 24'h408000, 24'h000000, 4'b1001);
      do_commit();
      check("commit_idle", 32'(cfg_busy), 32'h0);
      strobe(24'h00FFFF, 0);
      idle(1);
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_hit", 32'(rom_hit), 32'h1);
      check("t1_rom", 32'(is_rom), 32'h1);
      check("t1_addr", 32'(rom_addr), 32'h007FFF);
      check("t1_idx", 32'(w_idx), 32'h0);
      idle(1);
      check("t1_hold", 32'(rom_addr), 32'h007FFF);

      // Overlapping windows 1 and 3; lower index wins
      set_win(1, 24'h700000, 24'hF00000, 24'hE00000, 4'b0111);
      set_win(3, 24'h700000, 24'hF00000, 24'h000000, 4'b1001);
      do_commit();
      strobe(24'h700000, 0);
      idle(1);
      check("t2_idx", 32'(w_idx), 32'h1);
      check("t2_sram", 32'(is_sram), 32'h1);
      check("t2_addr", 32'(rom_addr), 32'hE00000);
      strobe(24'h00FFFF, 1);
      idle(1);
      check("t2_wp_rom", 32'(wp), 32'h1);
      strobe(24'h700000, 1);
      idle(1);
      check("t2_wp_sram", 32'(wp), 32'h0);

      // Offset wrap-around
      set_win(2, 24'h200000, 24'hFF0000, 24'hFFFF00, 4'b1001);
      do_commit();
      strobe(24'h200200, 0);
      idle(1);
      check("t3_wrap", 32'(rom_addr), 32'h000100);
      check("t3_idx", 32'(w_idx), 32'h2);

      // Commit while the bus strobes continuously
      set_win(0, 24'h008000, 24'h408000, 24'h100000, 4'b1001);
      vld = 1; addr = 24'h00FFFF; wr = 0; commit = 1;
      cycle();
      commit = 0;
      check("t4_busy0", 32'(cfg_busy), 32'h1);
      for (int k = 1; k < 5; k++) begin
         cycle();
         check("t4_busy", 32'(cfg_busy), 32'h1);
      end
      vld = 0;
      cycle();
      check("t4_gap1_busy", 32'(cfg_busy), 32'h1);
      cycle();
      check("t4_gap2_busy", 32'(cfg_busy), 32'h0);
      check("t4_old_addr", 32'(rom_addr), 32'h007FFF);
      strobe(24'h00FFFF, 0);
      idle(1);
      check("t4_new_addr", 32'(rom_addr), 32'h107FFF);

      // Random traffic mixed with table updates and commits
      for (int n = 0; n < 600; n++) begin
         vld = ($urandom_range(0, 99) < 60);
         case ($urandom_range(0, 3))
            0: addr = 24'($urandom);
            1: addr = 24'h700000 | 24'($urandom_range(0, 24'hFFFFF));
            2: addr = {8'($urandom), 1'b1, 15'($urandom)};
            default: addr = 24'h200000 | 24'($urandom_range(0, 65535));
         endcase
         wr = 1'($urandom_range(0, 1));
         we = ($urandom_range(0, 99) < 20);
         idx = 3'($urandom);
         field = 2'($urandom);
         if (field == 2'd1) begin
            case ($urandom_range(0, 3))
               0: data = 24'($urandom);
               1: data = 24'h0;
               2: data = 24'hF00000;
               default: data = 24'hFF0000;
            endcase
         end else if (field == 2'd3) begin
            data = 24'($urandom_range(0, 15));
         end else begin
            data = 24'($urandom);
         end
         commit = ($urandom_range(0, 99) < 8);
         cycle();
      end
      idle(4);

      // Reset with a pending commit and a full pipeline
      vld = 1; addr = 24'h00FFFF;
      cycle();
      commit = 1;
      cycle();
      commit = 0;
      check("pre_rst_busy", 32'(cfg_busy), 32'h1);
      rst_n = 0;
      cycle();
      check("rst_busy", 32'(cfg_busy), 32'h0);
      check("rst_valid2", 32'(out_valid), 32'h0);
      check("rst_outs2", dut_outs, 32'h0);
      rst_n = 1; vld = 0;
      strobe(24'h00FFFF, 0);
      idle(1);
      check("post_rst_valid", 32'(out_valid), 32'h1);
      check("post_rst_hit", 32'(rom_hit), 32'h0);
      check("post_rst_addr", 32'(rom_addr), 32'h0);

`ifdef ADDRMAP_HITCNT_EN
      set_win(2, 24'h200000, 24'hFF0000, 24'hFFFF00, 4'b1001);
      do_commit();
      cnt_sel = 3'd2;
      vld = 1; addr = 24'h200200; wr = 0;
      repeat (70000) cycle();
      check("cnt_sat", 32'(cnt_val), 32'h0000FFFF);
      vld = 0; cnt_clr = 1;
      cycle();
      cnt_clr = 0;
      cycle();
      check("cnt_clr", 32'(cnt_val), 32'h0);
      idle(3);
`endif

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
